// File: rtl/flexio_pkg.sv
// rtl/flexio_pkg.sv - shared constants for the FlexIO PCPI lane sequencer
package flexio_pkg;

  localparam logic [2:0] F_LOAD   = 3'b000;
  localparam logic [2:0] F_RUN    = 3'b001;
  localparam logic [2:0] F_SETDIV = 3'b010;
  localparam logic [2:0] F_STATUS = 3'b011;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  localparam logic [3:0] FULL_BITS = 4'd8;

endpackage

// File: rtl/flexio_lane_buf.sv
// rtl/flexio_lane_buf.sv - four A and four B serial lanes, right-shifting with zero fill
module flexio_lane_buf
  import flexio_pkg::*;
(
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load,
  input  logic [LANES*LANE_W-1:0] load_a,
  input  logic [LANES*LANE_W-1:0] load_b,
  input  logic                    shift_en,
  output logic [LANES-1:0]        bit0_a,
  output logic [LANES-1:0]        bit0_b
);

  logic [LANES-1:0][LANE_W-1:0] lane_a;
  logic [LANES-1:0][LANE_W-1:0] lane_b;

  always_ff @(posedge clk) begin
    if (clear) begin
      lane_a <= '0;
      lane_b <= '0;
    end else if (load) begin
      lane_a <= load_a;
      lane_b <= load_b;
    end else if (shift_en) begin
      for (int i = 0; i < LANES; i++) begin
        lane_a[i] <= lane_a[i] >> 1;
        lane_b[i] <= lane_b[i] >> 1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bit0
    assign bit0_a[g] = lane_a[g][0];
    assign bit0_b[g] = lane_b[g][0];
  end

endmodule

// File: rtl/flexio_seq_ctrl.sv
// rtl/flexio_seq_ctrl.sv - PCPI decode, bit-rate divider and shift-run sequencing for the lane buffer
module flexio_seq_ctrl
  import flexio_pkg::*;
#(
  parameter int         DIV_W  = 8,
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [3:0]  io_a,
  output logic [3:0]  io_b,
  output logic        shift_strobe
);

  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bits_left;
  logic [3:0]       run_left;
  logic [2:0]       funct3;
  logic [3:0]       run_n;
  logic             match;
  logic             shift_en;
  logic             lane_load;
  logic             unused_insn;

  assign funct3      = pcpi_insn[14:12];
  assign match       = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                       (pcpi_insn[31:25] == 7'd0) && !funct3[2];
  assign run_n       = (pcpi_rs1[3:0] > bits_left) ? bits_left : pcpi_rs1[3:0];
  assign shift_en    = (state == S_RUN) && (cnt == '0);
  assign lane_load   = (state == S_IDLE) && match && (funct3 == F_LOAD);
  assign shift_strobe = shift_en;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  flexio_lane_buf u_lane_buf (
    .clk      (clk),
    .clear    (!resetb),
    .load     (lane_load),
    .load_a   (pcpi_rs1),
    .load_b   (pcpi_rs2),
    .shift_en (shift_en),
    .bit0_a   (io_a),
    .bit0_b   (io_b)
  );

  // Single-cycle ops pulse ready in EXEC; runs pulse it in DONE, so DONE after EXEC is a quiet cycle.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= S_IDLE;
      div        <= '0;
      cnt        <= '0;
      bits_left  <= '0;
      run_left   <= '0;
      pcpi_rd    <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (match) begin
            pcpi_wait <= 1'b1;
            if ((funct3 == F_RUN) && (run_n != 4'd0)) begin
              state    <= S_RUN;
              cnt      <= div;
              run_left <= run_n;
              pcpi_rd  <= 32'(run_n);
            end else begin
              state      <= S_EXEC;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              case (funct3)
                F_LOAD: begin
                  bits_left <= FULL_BITS;
                  pcpi_rd   <= '0;
                end
                F_SETDIV: begin
                  div     <= pcpi_rs1[DIV_W-1:0];
                  pcpi_rd <= 32'(div);
                end
                F_STATUS: pcpi_rd <= {23'd0, 1'b0, bits_left, 4'd0};
                default:  pcpi_rd <= '0;
              endcase
            end
          end
        end
        S_EXEC: begin
          state      <= S_DONE;
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_wait  <= 1'b0;
        end
        S_RUN: begin
          if (shift_en) begin
            cnt       <= div;
            bits_left <= bits_left - 4'd1;
            run_left  <= run_left - 4'd1;
            if (run_left == 4'd1) begin
              state      <= S_DONE;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_wait  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flexio_seq_ctrl.sv
// tb/tb_flexio_seq_ctrl.sv - randomized self-checking bench against a lane-level reference model
module tb_flexio_seq_ctrl;

  localparam logic [6:0] OPC   = 7'b0001011;
  localparam int         LIMIT = 300;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [3:0]  io_a;
  logic [3:0]  io_b;
  logic        shift_strobe;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: lane bytes, remaining bits and divider
  logic [7:0] m_a [4];
  logic [7:0] m_b [4];
  int         m_bits = 0;
  int         m_div  = 0;

  always #5 clk = ~clk;

  flexio_seq_ctrl dut (
    .clk          (clk),
    .resetb       (resetb),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .shift_strobe (shift_strobe)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_io(input bit side_b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = side_b ? m_b[i][0] : m_a[i][0];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_a[i] = 8'd0;
      m_b[i] = 8'd0;
    end
    m_bits = 0;
    m_div  = 0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
    int          n = 0;
    int          d = m_div;
    int          lat = 1;
    int          cyc = 0;
    int          shifts = 0;
    int          bad_strobe = 0;
    int          wait_low = 0;
    bit          got = 1'b0;
    logic [31:0] rd_exp = '0;
    string       nm;
    case (f3)
      3'd0: begin
        nm = "load";
        for (int i = 0; i < 4; i++) begin
          m_a[i] = rs1[8*i +: 8];
          m_b[i] = rs2[8*i +: 8];
        end
        m_bits = 8;
      end
      3'd1: begin
        nm = "run";
        n = (int'(rs1[3:0]) > m_bits) ? m_bits : int'(rs1[3:0]);
        for (int i = 0; i < 4; i++) begin
          m_a[i] = m_a[i] >> n;
          m_b[i] = m_b[i] >> n;
        end
        m_bits -= n;
        rd_exp = n;
        lat = (n == 0) ? 1 : n * (d + 1) + 1;
      end
      3'd2: begin
        nm = "setdiv";
        rd_exp = m_div;
        m_div = int'(rs1[7:0]);
      end
      default: begin
        nm = "status";
        rd_exp = m_bits * 16;
      end
    endcase

    @(posedge clk);
    #1;
    pcpi_insn  = {7'd0, 10'($urandom), f3, 5'($urandom), OPC};
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    pcpi_valid = 1'b1;
    while (!got && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (shift_strobe) begin
        shifts++;
        if (n == 0 || (cyc % (d + 1)) != 0 || cyc > n * (d + 1)) bad_strobe++;
      end
      if (!pcpi_wait) wait_low++;
      if (pcpi_ready) begin
        got = 1'b1;
        expect_eq({nm, "_rd"}, pcpi_rd, rd_exp);
        expect_eq({nm, "_wr"}, 32'(pcpi_wr), 32'd1);
      end
    end
    expect_eq({nm, "_latency"}, cyc, lat);
    expect_eq({nm, "_shifts"}, shifts, n);
    expect_eq({nm, "_bad_strobe"}, bad_strobe, 0);
    expect_eq({nm, "_wait_low"}, wait_low, 0);
    @(posedge clk);
    #1;
    pcpi_valid = 1'b0;
    expect_eq({nm, "_ready_pulse"}, 32'(pcpi_ready), 32'd0);
    @(posedge clk);
    #1;
    expect_eq({nm, "_io_a"}, 32'(io_a), 32'(m_io(1'b0)));
    expect_eq({nm, "_io_b"}, 32'(io_b), 32'(m_io(1'b1)));
  endtask

  task automatic no_claim(input logic [31:0] insn);
    int hits = 0;
    @(posedge clk);
    #1;
    pcpi_insn  = insn;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    pcpi_valid = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (pcpi_wait || pcpi_ready || pcpi_wr || shift_strobe) hits++;
    end
    pcpi_valid = 1'b0;
    expect_eq("no_claim", hits, 0);
    expect_eq("no_claim_io_a", 32'(io_a), 32'(m_io(1'b0)));
  endtask

  task automatic random_nonmatch();
    logic [31:0] insn;
    insn = {7'd0, 10'($urandom), 3'($urandom_range(0, 3)), 5'($urandom), OPC};
    case ($urandom_range(0, 2))
      0:       insn[31:25] = 7'($urandom_range(1, 127));
      1:       insn[14:12] = 3'($urandom_range(4, 7));
      default: insn[6:0]   = OPC ^ 7'($urandom_range(1, 127));
    endcase
    no_claim(insn);
  endtask

  initial begin
    int          cyc;
    int          early_ready;
    logic [2:0]  f3;
    logic [31:0] rs1;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_ready", 32'(pcpi_ready), 32'd0);
    expect_eq("rst_wait", 32'(pcpi_wait), 32'd0);
    expect_eq("rst_wr", 32'(pcpi_wr), 32'd0);
    expect_eq("rst_rd", pcpi_rd, 32'd0);
    expect_eq("rst_io", {24'd0, io_a, io_b}, 32'd0);
    expect_eq("rst_strobe", 32'(shift_strobe), 32'd0);
    resetb = 1'b1;

    issue(3'd0, 32'h8040_2001, 32'h0000_00FF);
    expect_eq("plan_io_a", 32'(io_a), 32'h1);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd3, 32'd0);
    issue(3'd1, 32'd2, 32'd0);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd0, 32'd0);
    issue(3'd1, 32'd15, 32'd0);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd3, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    issue(3'd1, 32'd0, 32'd0);

    no_claim({7'd1, 10'd0, 3'b000, 5'd0, OPC});
    no_claim({7'd0, 10'd0, 3'b100, 5'd0, OPC});

    // Abort a long run with reset in its third cycle
    issue(3'd0, $urandom, $urandom);
    issue(3'd2, 32'd7, 32'd0);
    @(posedge clk);
    #1;
    pcpi_insn  = {7'd0, 10'd0, 3'b001, 5'd0, OPC};
    pcpi_rs1   = 32'd8;
    pcpi_valid = 1'b1;
    early_ready = 0;
    for (cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk);
      #1;
      if (pcpi_ready) early_ready++;
    end
    resetb = 1'b0;
    @(posedge clk);
    #1;
    resetb     = 1'b1;
    pcpi_valid = 1'b0;
    model_reset();
    expect_eq("abort_early_ready", early_ready, 0);
    expect_eq("abort_ready", 32'(pcpi_ready), 32'd0);
    expect_eq("abort_wait", 32'(pcpi_wait), 32'd0);
    expect_eq("abort_io", {24'd0, io_a, io_b}, 32'd0);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd2, 32'd0, 32'd0);
    issue(3'd0, 32'h0102_0304, 32'h0506_0708);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        random_nonmatch();
      end else begin
        f3  = 3'($urandom_range(0, 3));
        rs1 = $urandom;
        if (f3 == 3'd2) rs1[7:0] = 8'($urandom_range(0, 5));
        issue(f3, rs1, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flexio_seq_ctrl.md
# flexio_seq_ctrl

PCPI coprocessor that sequences the FlexIO lane shift buffer for picorv32. It decodes custom-0 instructions to load, run, configure and query four 8-bit serial lanes on two buses (A and B). It drives the lane shift enable from a programmable bit-rate divider and stalls the CPU until a shift run completes. It sits on the picorv32 PCPI port and owns the only instance of the lane buffer.

## Interface
Parameters:
- DIV_W, 8: width of the bit-period divider register.
- OPCODE, 7'b0001011: custom-0 major opcode matched in insn[6:0].

Ports:
- clk  in  1  clock.
- resetb  in  1  reset, synchronous, active-low.
- pcpi_valid  in  1  CPU presents an instruction; held until pcpi_ready.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  source operand 1.
- pcpi_rs2  in  32  source operand 2.
- pcpi_wr  out  1  rd write strobe, coincident with pcpi_ready.
- pcpi_rd  out  32  result value.
- pcpi_wait  out  1  instruction claimed, result pending.
- pcpi_ready  out  1  one-cycle completion pulse.
- io_a  out  4  bit 0 of each A lane (lane i = io_a[i]).
- io_b  out  4  bit 0 of each B lane.
- shift_strobe  out  1  copy of internal shift enable, for debug/pin sampling.

## Operation
- Match: pcpi_valid && insn[6:0]==OPCODE && insn[31:25]==0 && funct3 (insn[14:12]) in {000,001,010,011}. A non-matching instruction is never claimed: wait, ready and wr stay 0.
- LOAD (000): lane i of A <= rs1[8i+7:8i], lane i of B <= rs2[8i+7:8i]; bits_left <= 8; rd = 0.
- RUN (001): N = rs1[3:0], clamped to bits_left. Performs N shifts; each shift moves every lane right one bit with 0 fill. Decrements bits_left per shift. rd = N actually shifted. N==0 completes immediately with rd = 0.
- SETDIV (010): div <= rs1[DIV_W-1:0]; rd = previous div, zero-extended.
- STATUS (011): rd = {23'b0, busy(0), bits_left[3:0], 4'b0}. busy always reads 0 because RUN blocks.
- FSM states: IDLE, EXEC (single-cycle ops), RUN, DONE.
  - IDLE -> EXEC on match for LOAD/SETDIV/STATUS, or RUN with N==0.
  - IDLE -> RUN on match for RUN with N>0.
  - EXEC -> DONE.
  - RUN -> DONE after the Nth shift.
  - DONE -> IDLE unconditionally; pcpi_valid is ignored in DONE, because the CPU drops it that cycle.
- Divider: on entering RUN, tick counter <= div. Each cycle in RUN the counter decrements. At 0 it asserts shift_en for one cycle and reloads div.
- Reset values: pcpi_wr, pcpi_ready, pcpi_wait, shift_strobe = 0; pcpi_rd = 0; io_a, io_b = 0; lanes = 0; bits_left = 0; div = 0; state IDLE.
- resetb low during RUN aborts immediately: no pcpi_ready, outputs at reset values the next cycle.

## Timing
- Cycle 0: matching pcpi_valid sampled; decode and operands registered.
- Cycle 1 onward: pcpi_wait high until the ready cycle, inclusive.
- Single-cycle ops: pcpi_ready and pcpi_wr high in cycle 1, with pcpi_rd valid that same cycle.
- RUN with N>0 and divider D: shift k (k=1..N) occurs at cycle k*(D+1). pcpi_ready is at cycle N*(D+1)+1.
- io_a/io_b update the cycle after each shift_en, since they are registered lane bit 0.
- pcpi_rd is held at the last result after ready; it is only meaningful while pcpi_ready is high.

## Structure
- Package flexio_pkg: funct3 constants (F_LOAD, F_RUN, F_SETDIV, F_STATUS), OPCODE default, state encoding, lane count (4) and lane width (8).
- Sub-module flexio_lane_buf: 4x8 A and B lane registers with load (32-bit A/B words), shift_en and synchronous clear. It exposes bit 0 of each lane. The controller holds the FSM, divider, bits_left and PCPI logic.

## Test plan
- Reset, then LOAD rs1=0x8040_2001, rs2=0x0000_00FF -> ready at cycle 1, rd=0, io_a=4'b0001, io_b=4'b0001, STATUS rd=0x0000_0080.
- SETDIV rs1=3, then RUN rs1=2 -> shift_en at cycles 4 and 8, ready at cycle 9, rd=2, io_a=4'b0000, io_b=4'b0001, STATUS bits_left=6.
- RUN rs1=15 with bits_left=6, div=0 -> 6 shifts at cycles 1..6, ready at 7, rd=6, all io=0, bits_left=0.
- SETDIV rs1=5 after div=3 -> rd=3; RUN rs1=0 -> ready at cycle 1, rd=0, no shift_en.
- funct7=1 or funct3=100 with pcpi_valid held 20 cycles -> wait, ready and wr never asserted.
- resetb low at cycle 3 of a RUN with div=7, N=8 -> no ready, io=0, div=0 and bits_left=0 afterwards; next LOAD completes normally.
